// File: rtl/sys_if.sv
// sys_if -- memory request bus between the read-modify-write engine and memory.
//   addr : word address of the current request (engine -> memory)
//   dout : write data, valid while req=1 and wr=1 (engine -> memory)
//   req  : request, held high until acknowledged (engine -> memory)
//   wr   : request type, 1=write 0=read (engine -> memory)
//   din  : read data, valid with rdy during a read (memory -> engine)
//   rdy  : one-cycle acknowledge (memory -> engine)
interface sys_if;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        req;
  logic        wr;
  logic        rdy;

  modport master (output addr, output dout, output req, output wr,
                  input  din,  input  rdy);
  modport slave  (input  addr, input  dout, input  req, input  wr,
                  output din,  output rdy);
endinterface

// File: rtl/sys.sv
// sys -- random-access read-modify-write engine.
// Repeatedly reads the word at a pseudo-random address (LFSR state masked by
// range) and writes back that word plus one.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   m            : memory bus (sys_if master side)
//   seed0..seed3 : LFSR seed {seed3,seed2,seed1,seed0}, loaded during reset
//   range        : address mask, static during operation
module sys (
  input  logic        clk,
  input  logic        rst,
  sys_if.master       m,
  input  logic [15:0] seed0,
  input  logic [15:0] seed1,
  input  logic [15:0] seed2,
  input  logic [15:0] seed3,
  input  logic [63:0] range
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_REQ = 2'd1;
  localparam logic [1:0] WR_REQ = 2'd2;
  localparam logic [1:0] NEXT   = 2'd3;

  // Galois feedback mask for x^64+x^63+x^61+x^60+1 (right-shifting form).
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? TAPS : 64'h0);
  endfunction

  logic [63:0] seed_s;
  logic [63:0] seed_load_s;
  logic [1:0]  state_r;
  logic [63:0] lfsr_r;
  logic [63:0] addr_r;
  logic [63:0] data_r;   // captured read word, kept already incremented
  logic        req_r;
  logic        wr_r;

  assign seed_s = {seed3, seed2, seed1, seed0};

  // Seed substitution: an all-zero LFSR would lock up, so load 1 instead.
  always_comb begin
    seed_load_s = seed_s;
    if (seed_s == 64'h0) begin
      seed_load_s = 64'h1;
    end else begin
      seed_load_s = seed_s;
    end
  end

  assign m.addr = addr_r;
  assign m.dout = data_r;
  assign m.req  = req_r;
  assign m.wr   = wr_r;

  // Engine state machine; all bus outputs change only on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lfsr_r  <= seed_load_s;
      addr_r  <= 64'h0;
      data_r  <= 64'h0;
      req_r   <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, NEXT: begin
          // lfsr_r already holds the address source for this update
          state_r <= RD_REQ;
          addr_r  <= lfsr_r & range;
          req_r   <= 1'b1;
          wr_r    <= 1'b0;
        end
        RD_REQ: begin
          if (m.rdy) begin
            data_r  <= m.din + 64'd1;  // wraps modulo 2^64
            wr_r    <= 1'b1;
            state_r <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (m.rdy) begin
            lfsr_r  <= lfsr_step(lfsr_r);
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            state_r <= NEXT;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          wr_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys.sv
// tb_sys -- directed self-checking bench for sys.
module tb_sys;
  logic        clk;
  logic        rst;
  logic [15:0] seed0, seed1, seed2, seed3;
  logic [63:0] range;

  sys_if bus ();

  sys dut (
    .clk   (clk),
    .rst   (rst),
    .m     (bus),
    .seed0 (seed0),
    .seed1 (seed1),
    .seed2 (seed2),
    .seed3 (seed3),
    .range (range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] mem [0:8191];
  logic [63:0] lfsr_m;
  logic [63:0] a;
  logic [63:0] rd;

  function automatic logic [63:0] model_step(input logic [63:0] s);
    logic [63:0] n;
    n = {1'b0, s[63:1]};
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seed0 = 16'h0005; seed1 = 16'h0; seed2 = 16'h0; seed3 = 16'h0;
    range = 64'h1FFF;
    rst = 1'b1;
    bus.rdy = 1'b0;
    bus.din = 64'h0;
    tick(); tick();
    check("rst_req",  {63'd0, bus.req}, 64'd0);
    check("rst_wr",   {63'd0, bus.wr},  64'd0);
    check("rst_addr", bus.addr, 64'h0);
    check("rst_dout", bus.dout, 64'h0);

    // Release reset with a stray rdy pulse while idle: must be ignored.
    rst = 1'b0;
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    check("first_req",  {63'd0, bus.req}, 64'd1);
    check("first_wr",   {63'd0, bus.wr},  64'd0);
    check("first_addr", bus.addr, 64'h5);

    // Two-cycle read latency, request must stay put.
    tick();
    check("rd_hold_req",  {63'd0, bus.req}, 64'd1);
    check("rd_hold_addr", bus.addr, 64'h5);
    bus.rdy = 1'b1; bus.din = 64'h41;
    tick();
    bus.rdy = 1'b0;
    check("wr1_req",  {63'd0, bus.req}, 64'd1);
    check("wr1_wr",   {63'd0, bus.wr},  64'd1);
    check("wr1_addr", bus.addr, 64'h5);
    check("wr1_dout", bus.dout, 64'h42);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr1_hold_dout", bus.dout, 64'h42);
      check("wr1_hold_req",  {63'd0, bus.req}, 64'd1);
    end
    bus.rdy = 1'b1;
    tick();
    // NEXT: rdy stays high through the idle cycle and must have no effect.
    check("next1_req", {63'd0, bus.req}, 64'd0);
    tick();
    bus.rdy = 1'b0;
    check("rd2_req",  {63'd0, bus.req}, 64'd1);
    check("rd2_wr",   {63'd0, bus.wr},  64'd0);
    check("rd2_addr", bus.addr, 64'h2);  // step(5)=D800..0002, masked

    // All-ones read wraps to zero on write-back.
    bus.rdy = 1'b1; bus.din = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check("wrap_wr",   {63'd0, bus.wr}, 64'd1);
    check("wrap_dout", bus.dout, 64'h0);
    check("wrap_addr", bus.addr, 64'h2);
    tick();
    bus.rdy = 1'b0;
    check("next2_req", {63'd0, bus.req}, 64'd0);
    tick();
    check("rd3_addr", bus.addr, 64'h1);  // step(D800..0002)=6C00..0001

    // Random memory phase: 10 updates, 2-cycle read and 5-cycle write latency.
    for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
    lfsr_m = 64'h6C00_0000_0000_0001;
    for (int u = 0; u < 10; u++) begin
      a = lfsr_m & 64'h1FFF;
      check("rnd_rd_req",  {63'd0, bus.req}, 64'd1);
      check("rnd_rd_wr",   {63'd0, bus.wr},  64'd0);
      check("rnd_addr",    bus.addr, a);
      check("rnd_inrange", {63'd0, (bus.addr <= 64'h1FFF)}, 64'd1);
      tick();
      rd = mem[a[12:0]];
      bus.rdy = 1'b1; bus.din = rd;
      tick();
      bus.rdy = 1'b0; bus.din = 64'h0;
      check("rnd_wr",      {63'd0, bus.wr}, 64'd1);
      check("rnd_wr_addr", bus.addr, a);
      check("rnd_dout",    bus.dout, rd + 64'd1);
      for (int k = 0; k < 4; k++) tick();
      check("rnd_wr_hold", bus.dout, rd + 64'd1);
      mem[a[12:0]] = rd + 64'd1;
      bus.rdy = 1'b1;
      tick();
      bus.rdy = 1'b0;
      check("rnd_idle", {63'd0, bus.req}, 64'd0);
      tick();
      lfsr_m = model_step(lfsr_m);
    end

    // Reset while a write awaits rdy: write is dropped, seed address resumes.
    a = lfsr_m & 64'h1FFF;
    tick();
    bus.rdy = 1'b1; bus.din = 64'h7;
    tick();
    bus.rdy = 1'b0;
    check("pre_rst_wr", {63'd0, bus.wr}, 64'd1);
    tick();
    rst = 1'b1; bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    check("mid_rst_req",  {63'd0, bus.req}, 64'd0);
    check("mid_rst_wr",   {63'd0, bus.wr},  64'd0);
    check("mid_rst_dout", bus.dout, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_req",  {63'd0, bus.req}, 64'd1);
    check("post_rst_addr", bus.addr, 64'h5);

    // All-zero seed loads 1.
    seed0 = 16'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("zero_seed_addr", bus.addr, 64'h1);
    check("zero_seed_req",  {63'd0, bus.req}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
